// File: rtl/pi_client_ni_if.sv
// Client-side link bundle of the Pi-tree network interface: client TX/RX handshakes
// plus the router-facing packet ports.
interface pi_client_ni_if #(
    parameter int A_W = 4,
    parameter int D_W = 32
);
    logic           tx_valid;
    logic           tx_ready;
    logic [A_W-1:0] tx_addr;
    logic [D_W-1:0] tx_data;

    logic           rx_valid;
    logic           rx_ready;
    logic [D_W-1:0] rx_data;
    logic           rx_defl;

    logic           noc_i_v;
    logic           noc_i_defl;
    logic [A_W-1:0] noc_i_addr;
    logic [D_W-1:0] noc_i_data;

    logic           noc_o_v;
    logic           noc_o_defl;
    logic [A_W-1:0] noc_o_addr;
    logic [D_W-1:0] noc_o_data;

    // Client / router side
    modport master (
        output tx_valid, tx_addr, tx_data, rx_ready,
        output noc_i_v, noc_i_defl, noc_i_addr, noc_i_data,
        input  tx_ready, rx_valid, rx_data, rx_defl,
        input  noc_o_v, noc_o_defl, noc_o_addr, noc_o_data
    );

    // Network interface side
    modport slave (
        input  tx_valid, tx_addr, tx_data, rx_ready,
        input  noc_i_v, noc_i_defl, noc_i_addr, noc_i_data,
        output tx_ready, rx_valid, rx_data, rx_defl,
        output noc_o_v, noc_o_defl, noc_o_addr, noc_o_data
    );
endinterface

// File: rtl/pi_client_ni.sv
// Leaf network interface: TX FIFO injection, RX FIFO ejection, and one-cycle re-injection
// (deflection) of any arriving packet that cannot be accepted.
module pi_client_ni #(
    parameter int N        = 8,
    parameter int A_W      = $clog2(N) + 1,
    parameter int D_W      = 32,
    parameter int POSX     = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    pi_client_ni_if.slave       bus,
    output logic [15:0]         defl_cnt
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [A_W-1:0] POS_ADDR = A_W'(POSX);
    localparam logic [TAW:0]   TX_FULL  = (TAW + 1)'(TX_DEPTH);
    localparam logic [RAW:0]   RX_FULL  = (RAW + 1)'(RX_DEPTH);

    logic [A_W+D_W-1:0] tx_mem [TX_DEPTH];
    logic [D_W:0]       rx_mem [RX_DEPTH];

    logic [TAW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [TAW:0]   tx_cnt_q, tx_cnt_d;
    logic [RAW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [RAW:0]   rx_cnt_q, rx_cnt_d;

    logic           o_v_q, o_v_d, o_defl_q, o_defl_d;
    logic [A_W-1:0] o_addr_q, o_addr_d;
    logic [D_W-1:0] o_data_q, o_data_d;
    logic [15:0]    defl_cnt_q, defl_cnt_d;

    logic tx_ready, tx_push, tx_pop, rx_full, rx_nonempty, rx_push, rx_pop, bounce;
    logic [A_W+D_W-1:0] tx_head;
    logic [D_W:0]       rx_head;

    assign tx_head     = tx_mem[tx_rd_q];
    assign rx_head     = rx_mem[rx_rd_q];
    assign tx_ready    = (tx_cnt_q != TX_FULL);
    assign rx_full     = (rx_cnt_q == RX_FULL);
    assign rx_nonempty = (rx_cnt_q != '0);

    // Full flags use registered occupancy only, so a same-cycle RX read never makes room.
    assign bounce  = ce & bus.noc_i_v & ((bus.noc_i_addr != POS_ADDR) | rx_full);
    assign rx_push = ce & bus.noc_i_v & ~bounce;
    assign rx_pop  = ce & rx_nonempty & bus.rx_ready;
    assign tx_push = ce & bus.tx_valid & tx_ready;
    assign tx_pop  = ce & ~bounce & (tx_cnt_q != '0);

    always_comb begin
        tx_wr_d    = tx_push ? tx_wr_q + TAW'(1) : tx_wr_q;
        tx_rd_d    = tx_pop  ? tx_rd_q + TAW'(1) : tx_rd_q;
        rx_wr_d    = rx_push ? rx_wr_q + RAW'(1) : rx_wr_q;
        rx_rd_d    = rx_pop  ? rx_rd_q + RAW'(1) : rx_rd_q;
        tx_cnt_d   = tx_cnt_q;
        rx_cnt_d   = rx_cnt_q;
        o_v_d      = o_v_q;
        o_defl_d   = o_defl_q;
        o_addr_d   = o_addr_q;
        o_data_d   = o_data_q;
        defl_cnt_d = defl_cnt_q;

        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + (TAW + 1)'(1);
        else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - (TAW + 1)'(1);
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + (RAW + 1)'(1);
        else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - (RAW + 1)'(1);

        if (ce) begin
            if (bounce) begin
                o_v_d    = 1'b1;
                o_defl_d = 1'b1;
                o_addr_d = bus.noc_i_addr;
                o_data_d = bus.noc_i_data;
                if (defl_cnt_q != 16'hFFFF) defl_cnt_d = defl_cnt_q + 16'd1;
            end else if (tx_pop) begin
                o_v_d    = 1'b1;
                o_defl_d = 1'b0;
                o_addr_d = tx_head[A_W+D_W-1:D_W];
                o_data_d = tx_head[D_W-1:0];
            end else begin
                o_v_d    = 1'b0;
                o_defl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_cnt_q   <= '0;
            o_v_q      <= 1'b0;
            o_defl_q   <= 1'b0;
            o_addr_q   <= '0;
            o_data_q   <= '0;
            defl_cnt_q <= '0;
        end else begin
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            rx_cnt_q   <= rx_cnt_d;
            o_v_q      <= o_v_d;
            o_defl_q   <= o_defl_d;
            o_addr_q   <= o_addr_d;
            o_data_q   <= o_data_d;
            defl_cnt_q <= defl_cnt_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= {bus.tx_addr, bus.tx_data};
        if (rx_push) rx_mem[rx_wr_q] <= {bus.noc_i_defl, bus.noc_i_data};
    end

    assign bus.tx_ready   = tx_ready;
    assign bus.rx_valid   = rx_nonempty;
    assign bus.rx_data    = rx_nonempty ? rx_head[D_W-1:0] : '0;
    assign bus.rx_defl    = rx_nonempty & rx_head[D_W];
    assign bus.noc_o_v    = o_v_q;
    assign bus.noc_o_defl = o_defl_q;
    assign bus.noc_o_addr = o_addr_q;
    assign bus.noc_o_data = o_data_q;
    assign defl_cnt       = defl_cnt_q;
endmodule

// File: tb/tb_pi_client_ni.sv
// Bench for pi_client_ni: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_pi_client_ni;
    localparam int N = 8, A_W = 4, D_W = 32, POSX = 3, TX_DEPTH = 4, RX_DEPTH = 4;
    localparam logic [A_W-1:0] POS = A_W'(POSX);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce  = 1'b1;
    logic [15:0] defl_cnt;

    pi_client_ni_if #(.A_W(A_W), .D_W(D_W)) bus ();

    pi_client_ni #(
        .N(N), .A_W(A_W), .D_W(D_W), .POSX(POSX), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .bus(bus), .defl_cnt(defl_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFOs as queues, output register as plain variables.
    logic [A_W+D_W-1:0] m_tx[$];
    logic [D_W:0]       m_rx[$];
    logic               m_ov, m_odefl;
    logic [A_W-1:0]     m_oaddr;
    logic [D_W-1:0]     m_odata;
    int                 m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_tx.delete();
        m_rx.delete();
        m_ov = 1'b0; m_odefl = 1'b0; m_oaddr = '0; m_odata = '0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic bounce, accept, tx_push, rx_pop;
        logic [A_W+D_W-1:0] head;
        if (!rst) begin
            model_reset();
            return;
        end
        if (!ce) return;
        bounce  = bus.noc_i_v && (bus.noc_i_addr != POS || m_rx.size() == RX_DEPTH);
        accept  = bus.noc_i_v && !bounce;
        tx_push = bus.tx_valid && (m_tx.size() < TX_DEPTH);
        rx_pop  = bus.rx_ready && (m_rx.size() > 0);
        if (bounce) begin
            m_ov = 1'b1; m_odefl = 1'b1;
            m_oaddr = bus.noc_i_addr; m_odata = bus.noc_i_data;
            if (m_cnt < 65535) m_cnt++;
        end else if (m_tx.size() > 0) begin
            head = m_tx.pop_front();
            m_ov = 1'b1; m_odefl = 1'b0;
            m_oaddr = head[A_W+D_W-1:D_W]; m_odata = head[D_W-1:0];
        end else begin
            m_ov = 1'b0; m_odefl = 1'b0;
        end
        if (rx_pop) void'(m_rx.pop_front());
        if (accept) m_rx.push_back({bus.noc_i_defl, bus.noc_i_data});
        if (tx_push) m_tx.push_back({bus.tx_addr, bus.tx_data});
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("noc_o_v", 32'(bus.noc_o_v), 32'(m_ov));
            if (m_ov) chk("noc_o_defl", 32'(bus.noc_o_defl), 32'(m_odefl));
            chk("noc_o_addr", 32'(bus.noc_o_addr), 32'(m_oaddr));
            chk("noc_o_data", bus.noc_o_data, m_odata);
            chk("tx_ready", 32'(bus.tx_ready), 32'(m_tx.size() < TX_DEPTH));
            chk("rx_valid", 32'(bus.rx_valid), 32'(m_rx.size() > 0));
            if (m_rx.size() > 0) begin
                chk("rx_data", bus.rx_data, m_rx[0][D_W-1:0]);
                chk("rx_defl", 32'(bus.rx_defl), 32'(m_rx[0][D_W]));
            end
            chk("defl_cnt", 32'(defl_cnt), 32'(m_cnt));
        end
    end

    task automatic idle();
        bus.tx_valid = 1'b0; bus.tx_addr = '0; bus.tx_data = '0; bus.rx_ready = 1'b0;
        bus.noc_i_v = 1'b0; bus.noc_i_defl = 1'b0; bus.noc_i_addr = '0; bus.noc_i_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic send(input logic [A_W-1:0] a, input logic [D_W-1:0] d);
        bus.tx_valid = 1'b1; bus.tx_addr = a; bus.tx_data = d;
    endtask

    task automatic arrive(input logic [A_W-1:0] a, input logic [D_W-1:0] d, input logic f);
        bus.noc_i_v = 1'b1; bus.noc_i_addr = a; bus.noc_i_data = d; bus.noc_i_defl = f;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
    endtask

    int n;

    initial begin
        idle();
        model_reset();
        repeat (2) tick();
        rst = 1'b1;

        chk("rst_noc_o_v", 32'(bus.noc_o_v), 32'd0);
        chk("rst_noc_o_defl", 32'(bus.noc_o_defl), 32'd0);
        chk("rst_noc_o_addr", 32'(bus.noc_o_addr), 32'd0);
        chk("rst_noc_o_data", bus.noc_o_data, 32'd0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_rx_data", bus.rx_data, 32'd0);
        chk("rst_rx_defl", 32'(bus.rx_defl), 32'd0);
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_defl_cnt", 32'(defl_cnt), 32'd0);

        // Single send: write at cycle 0, visible at cycle 2.
        send(4'd5, 32'hA5A5_0001);
        tick();
        idle();
        chk("inj_c1_v", 32'(bus.noc_o_v), 32'd0);
        tick();
        chk("inj_c2_v", 32'(bus.noc_o_v), 32'd1);
        chk("inj_c2_addr", 32'(bus.noc_o_addr), 32'd5);
        chk("inj_c2_data", bus.noc_o_data, 32'hA5A5_0001);
        chk("inj_c2_defl", 32'(bus.noc_o_defl), 32'd0);
        tick();

        // Eject to this client.
        arrive(POS, 32'h1234, 1'b1);
        tick();
        idle();
        chk("ej_rx_valid", 32'(bus.rx_valid), 32'd1);
        chk("ej_rx_data", bus.rx_data, 32'h1234);
        chk("ej_rx_defl", 32'(bus.rx_defl), 32'd1);
        chk("ej_noc_o_v", 32'(bus.noc_o_v), 32'd0);
        bus.rx_ready = 1'b1;
        tick();
        idle();

        // Misdelivery while TX holds a packet: bounce first, TX next.
        pulse_reset();
        chk("mid_rst_cnt", 32'(defl_cnt), 32'd0);
        send(4'd1, 32'h3333);
        tick();
        idle();
        arrive(4'd6, 32'h6666, 1'b0);
        tick();
        idle();
        chk("mis_addr", 32'(bus.noc_o_addr), 32'd6);
        chk("mis_data", bus.noc_o_data, 32'h6666);
        chk("mis_defl", 32'(bus.noc_o_defl), 32'd1);
        chk("mis_cnt", 32'(defl_cnt), 32'd1);
        tick();
        chk("mis_tx_v", 32'(bus.noc_o_v), 32'd1);
        chk("mis_tx_addr", 32'(bus.noc_o_addr), 32'd1);
        chk("mis_tx_defl", 32'(bus.noc_o_defl), 32'd0);
        tick();

        // RX full: fifth packet bounces, head remains the first.
        for (int i = 0; i < 4; i++) begin
            arrive(POS, 32'h100 + i, 1'b0);
            tick();
        end
        arrive(POS, 32'hBEEF, 1'b0);
        tick();
        idle();
        chk("full_v", 32'(bus.noc_o_v), 32'd1);
        chk("full_defl", 32'(bus.noc_o_defl), 32'd1);
        chk("full_data", bus.noc_o_data, 32'hBEEF);
        chk("full_rx_head", bus.rx_data, 32'h100);
        chk("full_cnt", 32'(defl_cnt), 32'd2);
        bus.rx_ready = 1'b1;
        repeat (5) tick();
        idle();

        // TX full under a bounce stream, drain, then wrap with 6 more.
        arrive(4'd6, 32'hD0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send(A_W'(i), 32'h300 + i);
            tick();
        end
        idle();
        chk("txfull_ready", 32'(bus.tx_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("drain_v", 32'(bus.noc_o_v), 32'd1);
            chk("drain_data", bus.noc_o_data, 32'h300 + k);
        end
        for (int i = 0; i < 7; i++) begin
            if (i < 6) send(A_W'(i), 32'h400 + i);
            else idle();
            tick();
            if (i >= 1) begin
                chk("wrap_v", 32'(bus.noc_o_v), 32'd1);
                chk("wrap_data", bus.noc_o_data, 32'h400 + i - 1);
            end
        end
        idle();
        tick();

        // Randomized traffic with occasional mid-stream resets and ce gaps.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) != 0);
            if (!rst) model_reset();
            ce = ($urandom_range(0, 7) != 0);
            bus.tx_valid   = $urandom_range(0, 1);
            bus.tx_addr    = A_W'($urandom_range(0, N - 1));
            bus.tx_data    = $urandom;
            bus.noc_i_v    = $urandom_range(0, 1);
            bus.noc_i_addr = $urandom_range(0, 1) ? POS : A_W'($urandom_range(0, N - 1));
            bus.noc_i_data = $urandom;
            bus.noc_i_defl = $urandom_range(0, 1);
            bus.rx_ready   = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b1;
        ce  = 1'b1;
        idle();

        // Counter saturation with a 3-cycle ce gap mid-stream.
        pulse_reset();
        n = 0;
        for (int i = 0; i < 65540; i++) begin
            arrive(4'd6, 32'(i), 1'b0);
            if (i == 1000) begin
                chk("sat_pre_cnt", 32'(defl_cnt), 32'(n));
                ce = 1'b0;
                repeat (3) tick();
                chk("ce_hold_cnt", 32'(defl_cnt), 32'(n));
                chk("ce_hold_data", bus.noc_o_data, 32'd999);
                chk("ce_hold_v", 32'(bus.noc_o_v), 32'd1);
                ce = 1'b1;
            end
            tick();
            n++;
        end
        chk("sat_cnt", 32'(defl_cnt), 32'hFFFF);
        chk("sat_data", bus.noc_o_data, 32'(65539));
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
